// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU control block:
//   - ALUOP codes driven by main control
//   - R-type funct codes
//   - internal ALU-control enum produced by the decoder
//   - FSM state enum
//   - small classification helpers for the multiply/divide ops
// -----------------------------------------------------------------------------
package alu_pkg;

    // Operation classes from main control
    localparam logic [5:0] ALUOP_ADD   = 6'b000000;  // PC+4 style add
    localparam logic [5:0] ALUOP_SUB   = 6'b000001;  // branch compare
    localparam logic [5:0] ALUOP_FUNCT = 6'b000010;  // defer to funct field
    localparam logic [5:0] ALUOP_AND   = 6'b000011;
    localparam logic [5:0] ALUOP_OR    = 6'b000100;
    localparam logic [5:0] ALUOP_SLT   = 6'b000101;
    localparam logic [5:0] ALUOP_LUI   = 6'b000110;

    // R-type function field codes
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    // Internal ALU control, one value per distinct datapath behaviour
    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI,
        ALU_MULT,
        ALU_MULTU,
        ALU_DIV,
        ALU_DIVU,
        ALU_MFHI,
        ALU_MFLO,
        ALU_ILLEGAL
    } alu_ctrl_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_e;

    function automatic logic is_mul_op(input alu_ctrl_e c);
        return (c == ALU_MULT) || (c == ALU_MULTU);
    endfunction

    function automatic logic is_div_op(input alu_ctrl_e c);
        return (c == ALU_DIV) || (c == ALU_DIVU);
    endfunction

    function automatic logic is_signed_md(input alu_ctrl_e c);
        return (c == ALU_MULT) || (c == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// Iterative multiply / divide datapath with its iteration counter.
// Multiply is shift-add on magnitudes, divide is restoring division on
// magnitudes; one iteration per step, WIDTH iterations in total. The sign
// correction is combinational on the final raw values so the parent can
// capture corrected HI/LO in its fix-up cycle.
//
// Ports
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture operands and op kind, clear counter
//   is_div     : 1 = divide, 0 = multiply (sampled on load)
//   is_signed  : signed operation (sampled on load)
//   a, b       : operands A (multiplicand / dividend), B (multiplier / divisor)
//   step       : perform one iteration
//   last       : the current step is the final iteration
//   hi, lo     : sign-corrected results (product high/low, remainder/quotient)
// -----------------------------------------------------------------------------
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc;       // product high half / partial remainder
    logic [WIDTH-1:0] shreg;     // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
    logic             div_mode;
    logic             neg_res;   // product / quotient needs negation
    logic             neg_rem;   // remainder takes the dividend sign
    logic             div_zero;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
        mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
    end

    // One iteration of each algorithm; the carry/borrow bit lives only in
    // these WIDTH+1 intermediates.
    always_comb begin
        mul_sum  = {1'b0, acc} + {1'b0, (shreg[0] ? opnd : '0)};
        rem_sh   = {acc, shreg[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opnd};
    end

    assign last = (count == CNT_W'(WIDTH - 1));

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            acc      <= '0;
            shreg    <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            count    <= '0;
            acc      <= '0;
            div_mode <= is_div;
            div_zero <= is_div && (b == '0);
            neg_res  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= is_signed && a[WIDTH-1];
            if (is_div) begin
                shreg <= mag_a;
                opnd  <= mag_b;
            end else begin
                shreg <= mag_b;
                opnd  <= mag_a;
            end
        end else if (step) begin
            count <= last ? '0 : count + 1'b1;
            if (div_mode) begin
                // Restoring step: keep the difference only if it did not borrow.
                if (!rem_diff[WIDTH]) begin
                    acc   <= rem_diff[WIDTH-1:0];
                    shreg <= {shreg[WIDTH-2:0], 1'b1};
                end else begin
                    acc   <= rem_sh[WIDTH-1:0];
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc   <= mul_sum[WIDTH:1];
                shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
            end
        end
    end

    assign prod_fix = neg_res ? -{acc, shreg} : {acc, shreg};

    // A zero divisor never borrows, so the raw quotient is already all-ones
    // and the raw remainder is the dividend magnitude; only the quotient
    // negation has to be suppressed.
    always_comb begin
        hi = prod_fix[2*WIDTH-1:WIDTH];
        lo = prod_fix[WIDTH-1:0];
        if (div_mode) begin
            lo = div_zero ? '1 : (neg_res ? -shreg : shreg);
            hi = neg_rem ? -acc : acc;
        end
    end

endmodule

// File: rtl/alu_seq_control.sv
// -----------------------------------------------------------------------------
// alu_seq_control
// ALU control decode, single-cycle ALU and multi-cycle multiply/divide
// sequencer with HI/LO registers.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset          : asynchronous active-high reset
//   start          : issue one operation (ignored while busy)
//   ALUOP          : operation class from main control
//   funct          : R-type function field
//   shamt          : shift amount for sll/srl/sra
//   aluParamData1  : operand A
//   aluParamData2  : operand B
//   busy           : multi-cycle operation in progress
//   done           : one-cycle pulse, aluResult/zero valid
//   zero           : registered aluResult == 0
//   aluResult      : registered result
//   illegal        : one-cycle pulse for an undecodable ALUOP/funct
// -----------------------------------------------------------------------------
module alu_seq_control
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  ALUOP,
    input  logic [5:0]       funct,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] aluParamData1,
    input  logic [WIDTH-1:0] aluParamData2,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic [WIDTH-1:0] aluResult,
    output logic             illegal
);

    state_e           state;
    state_e           state_next;
    alu_ctrl_e        ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic             md_last;
    logic             md_load;
    logic             md_step;
    logic             fix;
    logic             issue_single;
    logic             issue_illegal;

    assign op_a = aluParamData1;
    assign op_b = aluParamData2;

    // ---------------------------------------------------------------- decode
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the case statements can infer a latch.
    always_comb begin
        ctrl = ALU_ILLEGAL;
        case (ALUOP)
            OP_W'(ALUOP_ADD): ctrl = ALU_ADD;
            OP_W'(ALUOP_SUB): ctrl = ALU_SUB;
            OP_W'(ALUOP_AND): ctrl = ALU_AND;
            OP_W'(ALUOP_OR):  ctrl = ALU_OR;
            OP_W'(ALUOP_SLT): ctrl = ALU_SLT;
            OP_W'(ALUOP_LUI): ctrl = ALU_LUI;
            OP_W'(ALUOP_FUNCT): begin
                case (funct)
                    FN_ADD, FN_ADDU: ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl = ALU_SUB;
                    FN_AND:          ctrl = ALU_AND;
                    FN_OR:           ctrl = ALU_OR;
                    FN_XOR:          ctrl = ALU_XOR;
                    FN_NOR:          ctrl = ALU_NOR;
                    FN_SLT:          ctrl = ALU_SLT;
                    FN_SLTU:         ctrl = ALU_SLTU;
                    FN_SLL:          ctrl = ALU_SLL;
                    FN_SRL:          ctrl = ALU_SRL;
                    FN_SRA:          ctrl = ALU_SRA;
                    FN_MULT:         ctrl = ALU_MULT;
                    FN_MULTU:        ctrl = ALU_MULTU;
                    FN_DIV:          ctrl = ALU_DIV;
                    FN_DIVU:         ctrl = ALU_DIVU;
                    FN_MFHI:         ctrl = ALU_MFHI;
                    FN_MFLO:         ctrl = ALU_MFLO;
                    default:         ctrl = ALU_ILLEGAL;
                endcase
            end
            default: ctrl = ALU_ILLEGAL;
        endcase
    end

    // ------------------------------------------------------ single-cycle ALU
    always_comb begin
        alu_res = '0;
        case (ctrl)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOR:  alu_res = ~(op_a | op_b);
            ALU_SLT:  alu_res = WIDTH'($signed(op_a) < $signed(op_b));
            ALU_SLTU: alu_res = WIDTH'(op_a < op_b);
            ALU_SLL:  alu_res = op_b << shamt;
            ALU_SRL:  alu_res = op_b >> shamt;
            ALU_SRA:  alu_res = $signed(op_b) >>> shamt;
            ALU_LUI:  alu_res = op_b << 16;
            ALU_MFHI: alu_res = hi_reg;
            ALU_MFLO: alu_res = lo_reg;
            default:  alu_res = '0;
        endcase
    end

    // ------------------------------------------------------- FSM: state reg
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------ FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start && is_mul_op(ctrl)) begin
                    state_next = ST_MUL;
                end else if (start && is_div_op(ctrl)) begin
                    state_next = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_last) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // --------------------------------------------------------- FSM: outputs
    // start is only looked at in IDLE, which is what makes it ignored while
    // busy; operands are captured by md_load on that same edge.
    always_comb begin
        busy          = 1'b0;
        md_load       = 1'b0;
        md_step       = 1'b0;
        fix           = 1'b0;
        issue_single  = 1'b0;
        issue_illegal = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (ctrl == ALU_ILLEGAL) begin
                        issue_illegal = 1'b1;
                    end else if (is_mul_op(ctrl) || is_div_op(ctrl)) begin
                        md_load = 1'b1;
                    end else begin
                        issue_single = 1'b1;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                busy    = 1'b1;
                md_step = 1'b1;
            end
            ST_FIX: begin
                busy = 1'b1;
                fix  = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------ multiply/divide engine
    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .load      (md_load),
        .is_div    (is_div_op(ctrl)),
        .is_signed (is_signed_md(ctrl)),
        .a         (op_a),
        .b         (op_b),
        .step      (md_step),
        .last      (md_last),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    // --------------------------------------------- result and HI/LO registers
    // Illegal ops pulse done without touching aluResult, zero, HI or LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aluResult <= '0;
            zero      <= 1'b1;
            done      <= 1'b0;
            illegal   <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            if (issue_single) begin
                aluResult <= alu_res;
                zero      <= (alu_res == '0);
                done      <= 1'b1;
            end
            if (issue_illegal) begin
                illegal <= 1'b1;
                done    <= 1'b1;
            end
            if (fix) begin
                hi_reg    <= md_hi;
                lo_reg    <= md_lo;
                aluResult <= md_lo;
                zero      <= (md_lo == '0);
                done      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_control.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_control
// Self-checking bench for alu_seq_control (WIDTH=32). A table of single-cycle
// vectors, hand-written multi-cycle sequences and a randomized run are all
// compared against a behavioural model that computes results with plain
// 64-bit arithmetic and tracks HI/LO and the last result.
// -----------------------------------------------------------------------------
module tb_alu_seq_control;

    localparam int WIDTH  = 32;
    localparam int OP_W   = 6;
    localparam int MD_LAT = WIDTH + 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [OP_W-1:0]   ALUOP;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [WIDTH-1:0]  aluParamData1;
    logic [WIDTH-1:0]  aluParamData2;
    logic              busy;
    logic              done;
    logic              zero;
    logic [WIDTH-1:0]  aluResult;
    logic              illegal;

    alu_seq_control #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .ALUOP         (ALUOP),
        .funct         (funct),
        .shamt         (shamt),
        .aluParamData1 (aluParamData1),
        .aluParamData2 (aluParamData2),
        .busy          (busy),
        .done          (done),
        .zero          (zero),
        .aluResult     (aluResult),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_res = '0;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[17];

    logic [11:0] legal_ops [25] = '{
        {6'd0, 6'h00}, {6'd1, 6'h00}, {6'd3, 6'h00}, {6'd4, 6'h00},
        {6'd5, 6'h00}, {6'd6, 6'h00},
        {6'd2, 6'h20}, {6'd2, 6'h21}, {6'd2, 6'h22}, {6'd2, 6'h23},
        {6'd2, 6'h24}, {6'd2, 6'h25}, {6'd2, 6'h26}, {6'd2, 6'h27},
        {6'd2, 6'h2A}, {6'd2, 6'h2B}, {6'd2, 6'h00}, {6'd2, 6'h02},
        {6'd2, 6'h03}, {6'd2, 6'h18}, {6'd2, 6'h19}, {6'd2, 6'h1A},
        {6'd2, 6'h1B}, {6'd2, 6'h10}, {6'd2, 6'h12}
    };

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural reference. kind: 0 single-cycle, 1 multiply/divide, 2 illegal.
    task automatic ref_apply(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                             input logic [31:0] a, input logic [31:0] b,
                             output int kind, output logic [31:0] er);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        kind = 0;
        er = '0;
        case (op)
            6'd0: er = a + b;
            6'd1: er = a - b;
            6'd3: er = a & b;
            6'd4: er = a | b;
            6'd5: er = (sa < sb) ? 32'd1 : 32'd0;
            6'd6: er = b << 16;
            6'd2: begin
                case (fn)
                    6'h20, 6'h21: er = a + b;
                    6'h22, 6'h23: er = a - b;
                    6'h24: er = a & b;
                    6'h25: er = a | b;
                    6'h26: er = a ^ b;
                    6'h27: er = ~(a | b);
                    6'h2A: er = (sa < sb) ? 32'd1 : 32'd0;
                    6'h2B: er = (ua < ub) ? 32'd1 : 32'd0;
                    6'h00: er = 32'(ub << sh);
                    6'h02: er = 32'(ub >> sh);
                    6'h03: er = 32'(sb >>> sh);
                    6'h18: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; kind = 1; end
                    6'h19: begin p = ua * ub;      m_hi = p[63:32]; m_lo = p[31:0]; kind = 1; end
                    6'h1A: begin
                        kind = 1;
                        if (b == 0) begin m_lo = '1; m_hi = a; end
                        else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
                    end
                    6'h1B: begin
                        kind = 1;
                        if (b == 0) begin m_lo = '1; m_hi = a; end
                        else begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
                    end
                    6'h10: er = m_hi;
                    6'h12: er = m_lo;
                    default: kind = 2;
                endcase
            end
            default: kind = 2;
        endcase
        if (kind == 1) er = m_lo;
        if (kind == 2) er = m_res;
        m_res = er;
    endtask

    // Issue one op and wait (bounded) for done; latency counts edges from the
    // one that samples start.
    task automatic run_op(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt,
                          output logic [31:0] res, output logic z, output logic ill);
        @(negedge clk);
        ALUOP = op; funct = fn; shamt = sh;
        aluParamData1 = a; aluParamData2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        res = aluResult;
        z   = zero;
        ill = illegal;
    endtask

    task automatic do_op(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                         input bit has_exp, input logic [31:0] exp, output int kind);
        logic [31:0] er;
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
        int          bc;
        ref_apply(op, fn, sh, a, b, kind, er);
        run_op(op, fn, sh, a, b, lat, bc, res, z, ill);
        check({name, " latency"}, lat, (kind == 1) ? MD_LAT : 1);
        check({name, " busy cycles"}, bc, (kind == 1) ? MD_LAT - 1 : 0);
        check({name, " illegal"}, ill, (kind == 2));
        check({name, " result"}, res, er);
        check({name, " zero"}, z, (er == 0));
        if (has_exp) check({name, " const"}, res, exp);
    endtask

    initial begin
        int          kind;
        int          lat;
        int          n_done;
        logic [11:0] pair;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] er;

        vecs[0]  = '{"add pc+4", 6'd0, 6'h00, 5'd0, 32'h00400000, 32'd4,        32'h00400004};
        vecs[1]  = '{"sub equal", 6'd1, 6'h00, 5'd0, 32'h1234,     32'h1234,     32'h0};
        vecs[2]  = '{"slt -1<1",  6'd5, 6'h00, 5'd0, 32'hFFFFFFFF, 32'd1,        32'd1};
        vecs[3]  = '{"sltu",      6'd2, 6'h2B, 5'd0, 32'hFFFFFFFF, 32'd1,        32'd0};
        vecs[4]  = '{"and",       6'd3, 6'h00, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
        vecs[5]  = '{"or",        6'd4, 6'h00, 5'd0, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0};
        vecs[6]  = '{"lui",       6'd6, 6'h00, 5'd0, 32'hDEADBEEF, 32'h00001234, 32'h12340000};
        vecs[7]  = '{"addu wrap", 6'd2, 6'h21, 5'd0, 32'hFFFFFFFF, 32'd2,        32'd1};
        vecs[8]  = '{"subu wrap", 6'd2, 6'h23, 5'd0, 32'd0,        32'd1,        32'hFFFFFFFF};
        vecs[9]  = '{"xor",       6'd2, 6'h26, 5'd0, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555};
        vecs[10] = '{"nor",       6'd2, 6'h27, 5'd0, 32'h0F0F0F0F, 32'h30303030, 32'hC0C0C0C0};
        vecs[11] = '{"sll",       6'd2, 6'h00, 5'd4, 32'd0,        32'h80000001, 32'h00000010};
        vecs[12] = '{"srl 31",    6'd2, 6'h02, 5'd31, 32'd0,       32'h80000000, 32'd1};
        vecs[13] = '{"sra",       6'd2, 6'h03, 5'd4, 32'd0,        32'h80000000, 32'hF8000000};
        vecs[14] = '{"slt f",     6'd2, 6'h2A, 5'd0, 32'd5,        32'hFFFFFFFB, 32'd0};
        vecs[15] = '{"sltu f",    6'd2, 6'h2B, 5'd0, 32'd5,        32'hFFFFFFFB, 32'd1};
        vecs[16] = '{"sub neg",   6'd1, 6'h00, 5'd0, 32'd3,        32'd5,        32'hFFFFFFFE};

        // Reset state
        reset = 1'b1; start = 1'b0; ALUOP = '0; funct = '0; shamt = '0;
        aluParamData1 = '0; aluParamData2 = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset illegal", illegal, 0);
        check("reset zero", zero, 1);
        check("reset aluResult", aluResult, 0);
        reset = 1'b0;

        // Single-cycle table
        foreach (vecs[i]) begin
            do_op(vecs[i].name, vecs[i].op, vecs[i].fn, vecs[i].sh,
                  vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp, kind);
        end

        // Multiply / divide corners
        do_op("mult -2*3", 6'd2, 6'h18, 5'd0, 32'hFFFFFFFE, 32'd3, 1'b1, 32'hFFFFFFFA, kind);
        do_op("mfhi mult", 6'd2, 6'h10, 5'd0, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, kind);
        do_op("mflo mult", 6'd2, 6'h12, 5'd0, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFA, kind);
        do_op("div -7/2",  6'd2, 6'h1A, 5'd0, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, kind);
        do_op("mfhi div",  6'd2, 6'h10, 5'd0, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, kind);
        do_op("divu 7/0",  6'd2, 6'h1B, 5'd0, 32'd7, 32'd0, 1'b1, 32'hFFFFFFFF, kind);
        do_op("mfhi divu0", 6'd2, 6'h10, 5'd0, 32'd0, 32'd0, 1'b1, 32'd7, kind);

        // Illegal decode leaves result and HI/LO alone
        do_op("illegal funct", 6'd2, 6'h3F, 5'd0, 32'd1, 32'd2, 1'b1, 32'd7, kind);
        do_op("illegal aluop", 6'd7, 6'h20, 5'd0, 32'd1, 32'd2, 1'b1, 32'd7, kind);
        do_op("mfhi after ill", 6'd2, 6'h10, 5'd0, 32'd0, 32'd0, 1'b1, 32'd7, kind);
        do_op("mflo after ill", 6'd2, 6'h12, 5'd0, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, kind);

        // start re-asserted with new operands while busy
        ref_apply(6'd2, 6'h18, 5'd0, 32'd6, 32'd7, kind, er);
        @(negedge clk);
        ALUOP = 6'd2; funct = 6'h18; aluParamData1 = 32'd6; aluParamData2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (lat == 5) begin
                start = 1'b1; funct = 6'h1B; aluParamData1 = 32'd100; aluParamData2 = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("busy-start latency", lat, MD_LAT);
        check("busy-start result", aluResult, 32'd42);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("busy-start extra done", n_done, 0);
        do_op("mfhi 6*7", 6'd2, 6'h10, 5'd0, 32'd0, 32'd0, 1'b1, 32'd0, kind);

        // Reset around iteration 10 of a multiply
        @(negedge clk);
        ALUOP = 6'd2; funct = 6'h18; aluParamData1 = 32'h12345678; aluParamData2 = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-abort busy", busy, 1);
        reset = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort aluResult", aluResult, 0);
        check("abort zero", zero, 1);
        m_hi = '0; m_lo = '0; m_res = '0;
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort no done", n_done, 0);
        do_op("mfhi abort", 6'd2, 6'h10, 5'd0, 32'd0, 32'd0, 1'b1, 32'd0, kind);
        do_op("mflo abort", 6'd2, 6'h12, 5'd0, 32'd0, 32'd0, 1'b1, 32'd0, kind);

        // start accepted on the first edge after reset release
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; ALUOP = 6'd0; aluParamData1 = 32'd1; aluParamData2 = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post-reset done", done, 1);
        check("post-reset result", aluResult, 32'd3);
        m_hi = '0; m_lo = '0; m_res = 32'd3;

        // Randomized run against the model
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    op = 6'($urandom_range(7, 63));
                    fn = 6'($urandom_range(0, 63));
                end else begin
                    op = 6'd2;
                    case ($urandom_range(0, 3))
                        0: fn = 6'h3F;
                        1: fn = 6'h01;
                        2: fn = 6'h2C;
                        default: fn = 6'h11;
                    endcase
                end
            end else begin
                pair = legal_ops[$urandom_range(0, 24)];
                op = pair[11:6];
                fn = pair[5:0];
            end
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
                2: begin a = $urandom; b = 32'd0; end
                default: begin
                    a = ($urandom_range(0, 1) == 0) ? 32'h80000000 : 32'hFFFFFFFF;
                    b = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : 32'h80000000;
                end
            endcase
            do_op("rand", op, fn, 5'($urandom_range(0, 31)), a, b, 1'b0, 32'd0, kind);
            if (kind == 1) begin
                do_op("rand mfhi", 6'd2, 6'h10, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, kind);
                do_op("rand mflo", 6'd2, 6'h12, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, kind);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
